pong_sync_gen: RTL and testbench
================================

PONG_SYNC_GEN -- requirements
Module: pong_sync_gen

Interface
REQ-001 Parameter H_TOTAL, default 455, clocks per line; HCNT counts 0..H_TOTAL-1.
REQ-002 Parameter V_TOTAL, default 262, lines per frame; VCNT counts 0..V_TOTAL-1.
REQ-003 CLK  in  1  single pixel clock, 7.159 MHz nominal; all state on its rising edge.
REQ-004 RESET_N  in  1  asynchronous active-low reset.
REQ-005 HCNT  out  9  horizontal count; bit0 = 1H ... bit8 = 256H.
REQ-006 VCNT  out  9  vertical count; bit0 = 1V ... bit8 = 256V.
REQ-007 HRESET / HRESET_N  out  1 each  end-of-line pulse and its complement.
REQ-008 VRESET / VRESET_N  out  1 each  end-of-frame line flag and its complement.
REQ-009 HBLANK / HBLANK_N  out  1 each  horizontal blanking and its complement.
REQ-010 HSYNC_N  out  1  horizontal sync, active low.
REQ-011 VBLANK / VBLANK_N  out  1 each  vertical blanking and its complement.
REQ-012 VSYNC_N  out  1  vertical sync, active low.

Function
REQ-013 HCNT shall increment by 1 every CLK; at H_TOTAL-1 (454) it shall wrap to 0 on the next edge.
REQ-014 HRESET shall be 1 exactly during the cycle HCNT==H_TOTAL-1, else 0; HRESET_N = ~HRESET always.
REQ-015 VCNT shall increment only on the edge where HCNT wraps (single clock domain, HRESET used as enable, no derived clock).
REQ-016 VCNT at V_TOTAL-1 (261) shall wrap to 0 on the edge where HCNT also wraps.
REQ-017 VRESET shall be 1 for the whole line VCNT==V_TOTAL-1, else 0; VRESET_N = ~VRESET.
REQ-018 HBLANK shall be 1 for HCNT 0..79 and 0 for HCNT 80..454; HBLANK_N = ~HBLANK.
REQ-019 HSYNC_N shall be 0 for HCNT 32..63 and 1 otherwise.
REQ-020 VBLANK shall be 1 for VCNT 0..15 and 0 for VCNT 16..261; VBLANK_N = ~VBLANK.
REQ-021 VSYNC_N shall be 0 for VCNT 4..7 and 1 otherwise.
REQ-022 All status outputs shall be registered and cycle-aligned with the count values they decode; no combinational glitches.
REQ-023 Frame length shall be H_TOTAL*V_TOTAL = 119210 clocks, about 16.65 ms at 7.159 MHz.
REQ-024 Counter wrap shall use ==, never overflow; counts outside range never occur after reset.

Reset
REQ-025 RESET_N low shall immediately force HCNT=0, VCNT=0, HRESET=0, VRESET=0, HBLANK=1, VBLANK=1, HSYNC_N=1, VSYNC_N=1, complements consistent.
REQ-026 On RESET_N release, counting shall start at the first rising CLK edge; reset asserted mid-line or mid-frame shall restart from HCNT=0, VCNT=0.
REQ-027 No simulation-only initialisation or forcing shall be needed for a valid first frame.

Configuration
REQ-028 With macro PONG_SYNC_COMPSYNC_EN defined, an extra output COMP_SYNC_N (1 bit) shall be HSYNC_N XNOR VSYNC_N, registered; without the macro, the port and its logic shall be absent.

Verification
REQ-029 Release reset, count 455 clocks -> HRESET high only at HCNT=454, HCNT=0 next cycle, VCNT=1.
REQ-030 Run one line -> HBLANK high for HCNT 0..79 (80 clocks), HSYNC_N low for HCNT 32..63 (32 clocks).
REQ-031 Run 2 full frames (238420 clocks) -> VRESET high for line 261 only, VCNT wraps 261->0, VBLANK 16 lines, VSYNC_N low for lines 4..7.
REQ-032 Assert RESET_N low at HCNT=200, VCNT=100 -> outputs take REQ-025 values asynchronously; resume from 0/0 after release.
REQ-033 Every cycle -> each _N output equals the complement of its pair; HSYNC_N low only while HBLANK=1.
REQ-034 With PONG_SYNC_COMPSYNC_EN -> COMP_SYNC_N low during hsync outside vsync and high during hsync inside lines 4..7.

Source files
------------

// File: rtl/pong_sync_gen.sv
// Raster timing generator for a Pong-style display: 455x262 counters with registered sync/blank decodes.
// Optional macro PONG_SYNC_COMPSYNC_EN adds a registered composite sync output COMP_SYNC_N.
module pong_sync_gen #(
  parameter int H_TOTAL = 455,
  parameter int V_TOTAL = 262
) (
  input  logic       CLK,
  input  logic       RESET_N,
  output logic [8:0] HCNT,
  output logic [8:0] VCNT,
  output logic       HRESET,
  output logic       HRESET_N,
  output logic       VRESET,
  output logic       VRESET_N,
  output logic       HBLANK,
  output logic       HBLANK_N,
  output logic       HSYNC_N,
  output logic       VBLANK,
  output logic       VBLANK_N,
  output logic       VSYNC_N
`ifdef PONG_SYNC_COMPSYNC_EN
  ,
  output logic       COMP_SYNC_N
`endif
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

  logic [8:0] h_nxt;
  logic [8:0] v_nxt;
  logic       hsync_n_nxt;
  logic       vsync_n_nxt;

  // Decodes are taken from the next count so every flag lands in the same cycle as its count.
  always_comb begin
    h_nxt = HRESET ? 9'd0 : HCNT + 9'd1;
    v_nxt = VCNT;
    if (HRESET)
      v_nxt = (VCNT == V_LAST) ? 9'd0 : VCNT + 9'd1;
    hsync_n_nxt = !((h_nxt >= 9'd32) && (h_nxt <= 9'd63));
    vsync_n_nxt = !((v_nxt >= 9'd4) && (v_nxt <= 9'd7));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      HCNT    <= 9'd0;
      VCNT    <= 9'd0;
      HRESET  <= 1'b0;
      VRESET  <= 1'b0;
      HBLANK  <= 1'b1;
      HSYNC_N <= 1'b1;
      VBLANK  <= 1'b1;
      VSYNC_N <= 1'b1;
    end else begin
      HCNT    <= h_nxt;
      VCNT    <= v_nxt;
      HRESET  <= (h_nxt == H_LAST);
      VRESET  <= (v_nxt == V_LAST);
      HBLANK  <= (h_nxt < 9'd80);
      HSYNC_N <= hsync_n_nxt;
      VBLANK  <= (v_nxt < 9'd16);
      VSYNC_N <= vsync_n_nxt;
    end
  end

  assign HRESET_N = ~HRESET;
  assign VRESET_N = ~VRESET;
  assign HBLANK_N = ~HBLANK;
  assign VBLANK_N = ~VBLANK;

`ifdef PONG_SYNC_COMPSYNC_EN
  // Inverts hsync during the vsync lines, serration-style.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) COMP_SYNC_N <= 1'b1;
    else          COMP_SYNC_N <= ~(hsync_n_nxt ^ vsync_n_nxt);
  end
`endif

endmodule

// File: tb/tb_pong_sync_gen.sv
// Bench for pong_sync_gen: a default-size instance and a shrunken-raster instance share clock and reset.
module tb_pong_sync_gen;

  localparam int DH = 455;
  localparam int DV = 262;
  localparam int SH = 100;
  localparam int SV = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] d_hc, d_vc, s_hc, s_vc;
  logic d_hr, d_hrn, d_vr, d_vrn, d_hb, d_hbn, d_hs, d_vb, d_vbn, d_vs;
  logic s_hr, s_hrn, s_vr, s_vrn, s_hb, s_hbn, s_hs, s_vb, s_vbn, s_vs;
`ifdef PONG_SYNC_COMPSYNC_EN
  logic d_cs, s_cs;
`endif

  pong_sync_gen u_def (
    .CLK(clk), .RESET_N(rst_n), .HCNT(d_hc), .VCNT(d_vc),
    .HRESET(d_hr), .HRESET_N(d_hrn), .VRESET(d_vr), .VRESET_N(d_vrn),
    .HBLANK(d_hb), .HBLANK_N(d_hbn), .HSYNC_N(d_hs),
    .VBLANK(d_vb), .VBLANK_N(d_vbn), .VSYNC_N(d_vs)
`ifdef PONG_SYNC_COMPSYNC_EN
    , .COMP_SYNC_N(d_cs)
`endif
  );

  pong_sync_gen #(.H_TOTAL(SH), .V_TOTAL(SV)) u_sml (
    .CLK(clk), .RESET_N(rst_n), .HCNT(s_hc), .VCNT(s_vc),
    .HRESET(s_hr), .HRESET_N(s_hrn), .VRESET(s_vr), .VRESET_N(s_vrn),
    .HBLANK(s_hb), .HBLANK_N(s_hbn), .HSYNC_N(s_hs),
    .VBLANK(s_vb), .VBLANK_N(s_vbn), .VSYNC_N(s_vs)
`ifdef PONG_SYNC_COMPSYNC_EN
    , .COMP_SYNC_N(s_cs)
`endif
  );

  // Reference: clocks elapsed since reset release; position follows by division.
  int t;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  int total, bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0d)", nm, act, exp, t);
    end
  endtask

  function automatic logic hs_of(input int h);
    return !((h >= 32) && (h <= 63));
  endfunction

  function automatic logic vs_of(input int v);
    return !((v >= 4) && (v <= 7));
  endfunction

  function automatic logic [31:0] exp_vec(input int h, input int v, input int ht, input int vt);
    logic hr, vr, hb, hs, vb, vs;
    hr = (h == ht - 1);
    vr = (v == vt - 1);
    hb = (h < 80);
    hs = hs_of(h);
    vb = (v < 16);
    vs = vs_of(v);
    return {2'b00, 9'(h), 9'(v), hr, !hr, vr, !vr, hb, !hb, hs, vb, !vb, vs};
  endfunction

  task automatic cyc_check();
    int dh, dv, sh, sv;
    dh = t % DH; dv = (t / DH) % DV;
    sh = t % SH; sv = (t / SH) % SV;
    chk("def_cyc", {2'b00, d_hc, d_vc, d_hr, d_hrn, d_vr, d_vrn, d_hb, d_hbn, d_hs, d_vb, d_vbn, d_vs},
        exp_vec(dh, dv, DH, DV));
    chk("sml_cyc", {2'b00, s_hc, s_vc, s_hr, s_hrn, s_vr, s_vrn, s_hb, s_hbn, s_hs, s_vb, s_vbn, s_vs},
        exp_vec(sh, sv, SH, SV));
`ifdef PONG_SYNC_COMPSYNC_EN
    chk("def_csync", 32'(d_cs), 32'(hs_of(dh) == vs_of(dv)));
    chk("sml_csync", 32'(s_cs), 32'(hs_of(sh) == vs_of(sv)));
`endif
  endtask

  typedef struct {
    int         cyc;
    logic [8:0] h, v;
    logic       hr, vr, hb, hs, vb, vs;
  } vec_t;

  vec_t tbl[15];
  localparam logic [31:0] RST_VEC = {8'd0, 9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int n;
    int c_vr, c_hr, c_hb, c_hs, c_vb, c_vs, c_wrap, c_bad_hs;
    total = 0;
    bad = 0;
    //           cyc    h    v   hr vr hb hs vb vs
    tbl[0]  = '{0,      0,   0,  0, 0, 1, 1, 1, 1};
    tbl[1]  = '{31,     31,  0,  0, 0, 1, 1, 1, 1};
    tbl[2]  = '{32,     32,  0,  0, 0, 1, 0, 1, 1};
    tbl[3]  = '{63,     63,  0,  0, 0, 1, 0, 1, 1};
    tbl[4]  = '{64,     64,  0,  0, 0, 1, 1, 1, 1};
    tbl[5]  = '{79,     79,  0,  0, 0, 1, 1, 1, 1};
    tbl[6]  = '{80,     80,  0,  0, 0, 0, 1, 1, 1};
    tbl[7]  = '{454,    454, 0,  1, 0, 0, 1, 1, 1};
    tbl[8]  = '{455,    0,   1,  0, 0, 1, 1, 1, 1};
    tbl[9]  = '{1852,   32,  4,  0, 0, 1, 0, 1, 0};
    tbl[10] = '{3639,   454, 7,  1, 0, 0, 1, 1, 0};
    tbl[11] = '{3640,   0,   8,  0, 0, 1, 1, 1, 1};
    tbl[12] = '{7279,   454, 15, 1, 0, 0, 1, 1, 1};
    tbl[13] = '{7280,   0,   16, 0, 0, 1, 1, 0, 1};
    tbl[14] = '{45700,  200, 100,0, 0, 0, 1, 0, 1};

    fork
      forever begin
        @(negedge clk);
        cyc_check();
      end
    join_none

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    foreach (tbl[i]) begin
      while (n < tbl[i].cyc) begin
        @(posedge clk);
        n++;
      end
      #2;
      chk($sformatf("tbl%0d", i),
          {8'd0, d_hc, d_vc, d_hr, d_vr, d_hb, d_hs, d_vb, d_vs},
          {8'd0, tbl[i].h, tbl[i].v, tbl[i].hr, tbl[i].vr, tbl[i].hb, tbl[i].hs, tbl[i].vb, tbl[i].vs});
    end

    // Mid-frame asynchronous reset at line 100, pixel 200: must act before the next edge.
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_def", {8'd0, d_hc, d_vc, d_hr, d_vr, d_hb, d_hs, d_vb, d_vs}, RST_VEC);
    chk("async_rst_def_n", {28'd0, d_hrn, d_vrn, d_hbn, d_vbn}, 32'b1100);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Two complete small-raster frames: tally decode widths.
    c_vr = 0; c_hr = 0; c_hb = 0; c_hs = 0; c_vb = 0; c_vs = 0; c_wrap = 0; c_bad_hs = 0;
    repeat (2 * SH * SV) begin
      @(negedge clk);
      if (s_vr) c_vr++;
      if (s_hr) c_hr++;
      if (s_hb) c_hb++;
      if (!s_hs) c_hs++;
      if (s_vb) c_vb++;
      if (!s_vs) c_vs++;
      if (s_hc == 9'd0 && s_vc == 9'd0) c_wrap++;
      if (!s_hs && !s_hb) c_bad_hs++;
    end
    chk("vreset_clks", 32'(c_vr), 32'(2 * SH));
    chk("hreset_clks", 32'(c_hr), 32'(2 * SV));
    chk("hblank_clks", 32'(c_hb), 32'(2 * SV * 80));
    chk("hsync_clks", 32'(c_hs), 32'(2 * SV * 32));
    chk("vblank_clks", 32'(c_vb), 32'(2 * SH * 16));
    chk("vsync_clks", 32'(c_vs), 32'(2 * SH * 4));
    chk("frame_starts", 32'(c_wrap), 32'd2);
    chk("hsync_in_blank", 32'(c_bad_hs), 32'd0);

    // Random reset pulses at random phase; the per-cycle model tracks both instances.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(50, 2000)) @(posedge clk);
      #($urandom_range(1, 3)) rst_n = 1'b0;
      #1;
      chk($sformatf("rnd_rst%0d", i), {8'd0, s_hc, s_vc, s_hr, s_vr, s_hb, s_hs, s_vb, s_vs}, RST_VEC);
      repeat ($urandom_range(1, 20)) @(negedge clk);
      #($urandom_range(1, 3)) rst_n = 1'b1;
    end

    repeat (5) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
